// File: rtl/dcache_ctrl_if.sv
// CPU-side and line-memory-side signal bundle for the L1 data cache controller.
// The slave modport is the cache's view; master is the CPU/memory environment.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              cpu_req_i;
    logic              cpu_write_i;
    logic [ADDR_W-1:0] cpu_addr_i;
    logic [31:0]       cpu_data_i;
    logic [31:0]       cpu_data_o;
    logic              cpu_stall_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [255:0]      mem_data_o;
    logic [255:0]      mem_data_i;
    logic              mem_ack_i;

    modport slave (
        input  cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        input  mem_data_i, mem_ack_i,
        output cpu_data_o, cpu_stall_o,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );

    modport master (
        output cpu_req_i, cpu_write_i, cpu_addr_i, cpu_data_i,
        output mem_data_i, mem_ack_i,
        input  cpu_data_o, cpu_stall_o,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
    );
endinterface

// File: rtl/dcache_ctrl.sv
// L1 data cache controller: direct-mapped, write-back, write-allocate.
// Hits complete in the same cycle; misses stall the CPU while a dirty victim is
// written back and the line is refilled from the 256-bit line memory.
module dcache_ctrl #(
    parameter int INDEX_W = 5,
    parameter int ADDR_W  = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,
    dcache_ctrl_if.slave  bus
);
    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 5;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2,
        S_FILL      = 2'd3
    } state_t;

    // Storage arrays: data and tags are not reset, only the valid/dirty bits are.
    logic [255:0]     r_data [LINES];
    logic [TAG_W-1:0] r_tag  [LINES];
    logic [LINES-1:0] r_valid;
    logic [LINES-1:0] r_dirty;

    state_t           r_state;
    logic             r_mem_en;
    logic             r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [255:0]     r_mem_data;

    logic [TAG_W-1:0]   w_tag;
    logic [INDEX_W-1:0] w_idx;
    logic [2:0]         w_word;
    logic [255:0]       w_line;
    logic [255:0]       w_store_line;
    logic               w_hit;
    logic               w_in_idle;
    logic [31:0]        w_rdata;
    logic [1:0]         w_unused_addr_bits;

    assign w_tag              = bus.cpu_addr_i[ADDR_W-1:INDEX_W+5];
    assign w_idx              = bus.cpu_addr_i[INDEX_W+4:5];
    assign w_word             = bus.cpu_addr_i[4:2];
    assign w_unused_addr_bits = bus.cpu_addr_i[1:0];
    assign w_line             = r_data[w_idx];
    assign w_in_idle          = (r_state == S_IDLE);

    // Hit is only meaningful while idle; other states are mid-miss by definition.
    assign w_hit = bus.cpu_req_i & r_valid[w_idx] & (r_tag[w_idx] == w_tag) & w_in_idle;

    // Word select for loads and word merge for stores.
    always_comb begin
        w_rdata      = w_line[{w_word, 5'b00000} +: 32];
        w_store_line = w_line;
        w_store_line[{w_word, 5'b00000} +: 32] = bus.cpu_data_i;
    end

    assign bus.cpu_data_o   = w_rdata;
    assign bus.cpu_stall_o  = ~rst_i & bus.cpu_req_i & ~w_hit;
    assign bus.mem_enable_o = r_mem_en;
    assign bus.mem_write_o  = r_mem_wr;
    assign bus.mem_addr_o   = r_mem_addr;
    assign bus.mem_data_o   = r_mem_data;

    // Miss-handling FSM with registered memory-request outputs and valid/dirty bits.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state    <= S_IDLE;
            r_valid    <= '0;
            r_dirty    <= '0;
            r_mem_en   <= 1'b0;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_hit && bus.cpu_write_i) begin
                        r_dirty[w_idx] <= 1'b1;
                    end else if (bus.cpu_req_i && !w_hit) begin
                        r_mem_en <= 1'b1;
                        if (r_dirty[w_idx]) begin
                            // Dirty victim: push the old line out before refilling.
                            r_state    <= S_WRITEBACK;
                            r_mem_wr   <= 1'b1;
                            r_mem_addr <= {r_tag[w_idx], w_idx, 5'b00000};
                            r_mem_data <= w_line;
                        end else begin
                            r_state    <= S_ALLOCATE;
                            r_mem_wr   <= 1'b0;
                            r_mem_addr <= {w_tag, w_idx, 5'b00000};
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (bus.mem_ack_i) begin
                        // Back-to-back request: enable stays high into the refill read.
                        r_state    <= S_ALLOCATE;
                        r_mem_wr   <= 1'b0;
                        r_mem_addr <= {w_tag, w_idx, 5'b00000};
                    end
                end
                S_ALLOCATE: begin
                    if (bus.mem_ack_i) begin
                        r_state  <= S_FILL;
                        r_mem_en <= 1'b0;
                    end
                end
                S_FILL: begin
                    r_state        <= S_IDLE;
                    r_valid[w_idx] <= 1'b1;
                    r_dirty[w_idx] <= 1'b0;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mem_en <= 1'b0;
                    r_mem_wr <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: store hits merge a word, refills replace the whole line and tag.
    always_ff @(posedge clk_i) begin
        if (w_hit && bus.cpu_write_i) begin
            r_data[w_idx] <= w_store_line;
        end else if (r_state == S_FILL) begin
            r_data[w_idx] <= bus.mem_data_i;
            r_tag[w_idx]  <= w_tag;
        end
    end
endmodule
